// File: rtl/cic_pkg.sv
// Shared constants and width helper for the N-stage CIC decimator.
package cic_pkg;

  localparam int N_MAX = 6;
  localparam int R_MAX = 64;

  // Hogenauer growth bound for M = 1: every bit the integrator chain can need.
  function automatic int cic_out_width(input int iw, input int n, input int r);
    return iw + n * $clog2(r);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section: strobe-gated y = x - x[-1] at the decimated rate.
module cic_comb_stage #(
  parameter int W = 21
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_stb,
  input  logic [W-1:0] i_data,
  output logic         o_stb,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_dly;
  logic [W-1:0] r_comb;
  logic         r_stb;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dly  <= '0;
      r_comb <= '0;
      r_stb  <= 1'b0;
    end else begin
      r_stb <= i_stb;
      if (i_stb) begin
        r_comb <= i_data - r_dly;
        r_dly  <= i_data;
      end
    end
  end

  assign o_stb  = r_stb;
  assign o_data = r_comb;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at the input rate, decimate by R, combs at the output rate.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IW = 12,
  parameter int N  = 3,
  parameter int R  = 8,
  parameter int OW = 21
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [IW-1:0] i_data,
  output logic [OW-1:0] o_data,
  output logic          o_valid
);

  localparam int CW = $clog2(R);
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  generate
    if (OW != cic_out_width(IW, N, R)) begin : g_bad_ow
      $error("cic_decimator: OW must equal IW + N*log2(R)");
    end
    if (N < 1 || N > N_MAX) begin : g_bad_n
      $error("cic_decimator: N out of range 1..6");
    end
    if (R < 2 || R > R_MAX || (R & (R - 1)) != 0) begin : g_bad_r
      $error("cic_decimator: R must be a power of two in 2..64");
    end
  endgenerate

  // i_ce and o_valid are single-cycle qualifiers with no ready: every i_ce
  // consumes i_data, and every o_valid pulse must be taken by the consumer.

  logic [OW-1:0] w_in_ext;
  logic [OW-1:0] r_int [N];
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_dec_data;
  logic          r_dec_stb;

  assign w_in_ext = OW'($signed(i_data));

  // Pipelined integrators: each stage adds the pre-edge value of its predecessor.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N; k++) r_int[k] <= '0;
    end else if (i_ce) begin
      r_int[0] <= r_int[0] + w_in_ext;
      for (int k = 1; k < N; k++) r_int[k] <= r_int[k] + r_int[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt      <= '0;
      r_dec_data <= '0;
      r_dec_stb  <= 1'b0;
    end else if (i_ce && r_cnt == CNT_LAST) begin
      r_cnt      <= '0;
      r_dec_data <= r_int[N-1];
      r_dec_stb  <= 1'b1;
    end else begin
      r_dec_stb <= 1'b0;
      if (i_ce) r_cnt <= r_cnt + 1'b1;
    end
  end

  logic [OW-1:0] w_x [N+1];
  logic [N:0]    w_s;

  assign w_x[0] = r_dec_data;
  assign w_s[0] = r_dec_stb;

  generate
    for (genvar k = 0; k < N; k++) begin : g_comb
      cic_comb_stage #(.W(OW)) u_comb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_stb     (w_s[k]),
        .i_data    (w_x[k]),
        .o_stb     (w_s[k+1]),
        .o_data    (w_x[k+1])
      );
    end
  endgenerate

  assign o_data  = w_x[N];
  assign o_valid = w_s[N];

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: DC table, impulse phases, gapped strobe, reset and parameter sweep.
module tb_cic_decimator;

  localparam int IW = 12;
  localparam int N  = 3;
  localparam int R  = 8;
  localparam int OW = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          rst_n;
  logic          ce;
  logic [IW-1:0] din;
  logic [OW-1:0] dout;
  logic          vld;
  logic [IW-1:0] one_d = 12'd1;

  cic_decimator #(.IW(IW), .N(N), .R(R), .OW(OW)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(din), .o_data(dout), .o_valid(vld)
  );

  // Parameter-sweep instances, all fed a constant 1 on the shared strobe.
  logic [12:0] s0_d; logic s0_v;
  logic [17:0] s1_d; logic s1_v;
  logic [17:0] s2_d; logic s2_v;
  logic [47:0] s3_d; logic s3_v;

  cic_decimator #(.IW(12), .N(1), .R(2), .OW(13)) u_s0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(one_d), .o_data(s0_d), .o_valid(s0_v)
  );
  cic_decimator #(.IW(12), .N(1), .R(64), .OW(18)) u_s1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(one_d), .o_data(s1_d), .o_valid(s1_v)
  );
  cic_decimator #(.IW(12), .N(6), .R(2), .OW(18)) u_s2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(one_d), .o_data(s2_d), .o_valid(s2_v)
  );
  cic_decimator #(.IW(12), .N(6), .R(64), .OW(48)) u_s3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(one_d), .o_data(s3_d), .o_valid(s3_v)
  );

  // ---------------- monitor / scoreboard ----------------
  logic [OW-1:0] cap_q[$];
  int            cap_cyc[$];
  logic [OW-1:0] exp_q[$];
  int            vexp[$];
  longint        last_s[4];

  always @(negedge clk) begin
    if (vld) begin
      cap_q.push_back(dout);
      cap_cyc.push_back(cyc);
    end
    if (s0_v) last_s[0] = longint'($signed(s0_d));
    if (s1_v) last_s[1] = longint'($signed(s1_d));
    if (s2_v) last_s[2] = longint'($signed(s2_d));
    if (s3_v) last_s[3] = longint'($signed(s3_d));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    ce    = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete();
    cap_cyc.delete();
  endtask

  // Drives one accepted sample; returns the cycle index of the sampling edge.
  task automatic send(input logic [IW-1:0] d, output int edge_idx);
    @(negedge clk);
    ce       = 1'b1;
    din      = d;
    edge_idx = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b0;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int     din;
    longint first;   // first output: 35 * din (h[0..4] of the N=3, R=8 response)
    longint steady;  // R^N * din
  } dc_vec_t;

  dc_vec_t dc_tab[5];

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e, e_first, total;
    longint sum;
    logic [IW-1:0] rnd[64];

    dc_tab[0] = '{1, 35, 512};
    dc_tab[1] = '{-2048, -71680, -1048576};
    dc_tab[2] = '{2047, 71645, 1048064};
    dc_tab[3] = '{100, 3500, 51200};
    dc_tab[4] = '{-1, -35, -512};

    rst_n = 1'b0;
    ce    = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    chk("reset_data", longint'($signed(dout)), 0);
    chk("reset_valid", longint'(vld), 0);

    // DC table: latency, spacing, transient and steady values.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      e_first = 0;
      for (int s = 0; s < 64; s++) begin
        send(IW'(dc_tab[i].din), e);
        if (s == R - 1) e_first = e;
      end
      idle(N + 3);
      chk("dc_count", cap_q.size(), 8);
      if (cap_q.size() > 0) begin
        chk("dc_first_latency", cap_cyc[0], e_first + N);
        chk("dc_first_value", longint'($signed(cap_q[0])), dc_tab[i].first);
      end
      for (int j = 1; j < cap_q.size(); j++)
        chk("dc_spacing", cap_cyc[j] - cap_cyc[j-1], R);
      for (int j = N; j < cap_q.size(); j++)
        chk("dc_steady", longint'($signed(cap_q[j])), dc_tab[i].steady);
    end

    // Impulse at each decimation phase: each polyphase branch sums to R^(N-1),
    // so the eight phases together sum to R^N.
    total = 0;
    for (int ph = 0; ph < R; ph++) begin
      do_reset();
      for (int s = 0; s < 64; s++) send((s == ph) ? IW'(1) : IW'(0), e);
      idle(N + 3);
      sum = 0;
      foreach (cap_q[j]) sum += longint'($signed(cap_q[j]));
      chk("impulse_phase_sum", sum, 64);
      if (cap_q.size() > 0) chk("impulse_tail_zero", longint'($signed(cap_q[cap_q.size()-1])), 0);
      total += int'(sum);
    end
    chk("impulse_total_sum", total, 512);

    // Gapped strobe: identical output sequence, latency N after each decimating edge.
    foreach (rnd[i]) rnd[i] = IW'($urandom_range(0, 4095));
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      vexp.delete();
      for (int s = 0; s < 64; s++) begin
        if (pass == 1) idle($urandom_range(0, 5));
        send(rnd[s], e);
        if (s % R == R - 1) vexp.push_back(e + N);
      end
      idle(N + 3);
      chk("gap_count", cap_q.size(), 8);
      for (int j = 0; j < cap_cyc.size() && j < vexp.size(); j++)
        chk("gap_latency", cap_cyc[j], vexp[j]);
      if (pass == 0) begin
        exp_q = cap_q;
      end else begin
        foreach (cap_q[j]) begin
          if (exp_q.size() == 0) begin
            chk("gap_extra_output", 1, 0);
          end else begin
            chk("gap_sequence", longint'($signed(cap_q[j])), longint'($signed(exp_q.pop_front())));
          end
        end
      end
    end

    // Reset mid-stream: 13 samples of DC 100, one cycle of reset, then restart.
    do_reset();
    for (int s = 0; s < 13; s++) send(IW'(100), e);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_data", longint'($signed(dout)), 0);
    chk("midreset_valid", longint'(vld), 0);
    @(negedge clk);
    chk("midreset_data_hold", longint'($signed(dout)), 0);
    chk("midreset_valid_hold", longint'(vld), 0);
    rst_n = 1'b1;
    ce    = 1'b0;
    cap_q.delete();
    cap_cyc.delete();
    e_first = 0;
    for (int s = 0; s < R; s++) begin
      send(IW'(100), e);
      if (s == R - 1) e_first = e;
    end
    idle(N + 3);
    chk("postreset_count", cap_q.size(), 1);
    if (cap_q.size() > 0) begin
      chk("postreset_latency", cap_cyc[0], e_first + N);
      chk("postreset_value", longint'($signed(cap_q[0])), 3500);
    end

    // Parameter sweep: DC of 1 settles to R^N for every corner.
    foreach (last_s[i]) last_s[i] = -1;
    do_reset();
    for (int s = 0; s < 512; s++) send(IW'(1), e);
    idle(8);
    chk("sweep_n1_r2", last_s[0], 2);
    chk("sweep_n1_r64", last_s[1], 64);
    chk("sweep_n6_r2", last_s[2], 64);
    chk("sweep_n6_r64", last_s[3], 64'd68719476736);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
